// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the ibus/dbus system-bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_e;

  localparam logic       TAG_READ        = 1'b1;
  localparam logic       TAG_WRITE       = 1'b0;
  localparam logic [3:0] TAG_TYPE_MEMORY = 4'b0001;

  localparam int DEFAULT_BURST_BEATS = 8;
  localparam int BEAT_CNT_W          = $clog2(DEFAULT_BURST_BEATS);

  // Counter width that stays legal for a single-beat burst.
  function automatic int beat_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_burst_counter.sv
// Tracks an outstanding read burst: pending flag plus response beat count.
module bus_arbiter_burst_counter
  import bus_arb_pkg::*;
#(
  parameter int BURST_BEATS = DEFAULT_BURST_BEATS,
  parameter int CNT_W       = beat_cnt_w(BURST_BEATS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic read_accept_i,
  input  logic beat_i,
  output logic pending_o,
  output logic last_beat_o
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

  logic             pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last_beat_o = pending_q & beat_i & (cnt_q == LAST_BEAT);
  assign pending_o   = pending_q;

  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    if (pending_q && beat_i) begin
      if (cnt_q == LAST_BEAT) begin
        pending_d = 1'b0;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (read_accept_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (ibus fetch / dbus data) to one system-bus arbiter with burst tracking.
// Optional ARB_ROUND_ROBIN_EN: simultaneous IDLE requests alternate instead of dbus priority.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BURST_BEATS    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BUS_DATA_WIDTH-1:0] ibus_req,
  input  logic                      ibus_reqcyc,
  input  logic [BUS_TAG_WIDTH-1:0]  ibus_reqtag,
  output logic                      ibus_reqack,
  output logic                      ibus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] ibus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ibus_resptag,
  input  logic                      ibus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] dbus_req,
  input  logic                      dbus_reqcyc,
  input  logic [BUS_TAG_WIDTH-1:0]  dbus_reqtag,
  output logic                      dbus_reqack,
  output logic                      dbus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] dbus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  dbus_resptag,
  input  logic                      dbus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic                      bus_reqcyc,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int TAG_RW_BIT = BUS_TAG_WIDTH - 1;

  arb_state_e state_q, state_d;
  logic       owner_reqcyc;
  logic       read_accept, beat, pending, last_beat;

  // Routing: only the owner sees acks and response-valid; data and tags are broadcast.
  always_comb begin
    bus_req      = '0;
    bus_reqcyc   = 1'b0;
    bus_reqtag   = '0;
    bus_respack  = 1'b0;
    ibus_reqack  = 1'b0;
    ibus_respcyc = 1'b0;
    dbus_reqack  = 1'b0;
    dbus_respcyc = 1'b0;
    owner_reqcyc = 1'b0;
    ibus_resp    = bus_resp;
    ibus_resptag = bus_resptag;
    dbus_resp    = bus_resp;
    dbus_resptag = bus_resptag;
    case (state_q)
      IGRANT: begin
        bus_req      = ibus_req;
        bus_reqcyc   = ibus_reqcyc;
        bus_reqtag   = ibus_reqtag;
        bus_respack  = ibus_respack;
        ibus_reqack  = bus_reqack;
        ibus_respcyc = bus_respcyc;
        owner_reqcyc = ibus_reqcyc;
      end
      DGRANT: begin
        bus_req      = dbus_req;
        bus_reqcyc   = dbus_reqcyc;
        bus_reqtag   = dbus_reqtag;
        bus_respack  = dbus_respack;
        dbus_reqack  = bus_reqack;
        dbus_respcyc = bus_respcyc;
        owner_reqcyc = dbus_reqcyc;
      end
      default: ;
    endcase
  end

  assign read_accept = bus_reqcyc & bus_reqack & (bus_reqtag[TAG_RW_BIT] == TAG_READ);
  assign beat        = bus_respcyc & bus_respack;

  bus_arbiter_burst_counter #(
    .BURST_BEATS (BURST_BEATS)
  ) u_burst_counter (
    .clk           (clk),
    .rst_n         (reset),
    .read_accept_i (read_accept),
    .beat_i        (beat),
    .pending_o     (pending),
    .last_beat_o   (last_beat)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dbus_q, last_dbus_d;

  always_comb begin
    last_dbus_d = last_dbus_q;
    if (state_q == IDLE && state_d != IDLE) begin
      last_dbus_d = (state_d == DGRANT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_dbus_q <= 1'b0;
    end else begin
      last_dbus_q <= last_dbus_d;
    end
  end
`endif

  // The grant drops on the edge that closes the final beat, so IDLE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (dbus_reqcyc && ibus_reqcyc) begin
          state_d = last_dbus_q ? IGRANT : DGRANT;
        end else if (dbus_reqcyc) begin
          state_d = DGRANT;
        end else if (ibus_reqcyc) begin
          state_d = IGRANT;
        end
`else
        if (dbus_reqcyc) begin
          state_d = DGRANT;
        end else if (ibus_reqcyc) begin
          state_d = IGRANT;
        end
`endif
      end
      IGRANT, DGRANT: begin
        if (!owner_reqcyc && (!pending || last_beat)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios then randomized traffic vs. a transaction model.
module tb_bus_arbiter;

  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int BEATS = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] ibus_req, dbus_req, bus_resp;
  logic [TW-1:0] ibus_reqtag, dbus_reqtag, bus_resptag;
  logic          ibus_reqcyc, dbus_reqcyc, ibus_respack, dbus_respack;
  logic          bus_reqack, bus_respcyc;
  logic          ibus_reqack, ibus_respcyc, dbus_reqack, dbus_respcyc;
  logic [DW-1:0] ibus_resp, dbus_resp, bus_req;
  logic [TW-1:0] ibus_resptag, dbus_resptag, bus_reqtag;
  logic          bus_reqcyc, bus_respack;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: owner 0 = none, 1 = ibus, 2 = dbus
  int m_owner, m_pend, m_beats, m_last;

  localparam logic [TW-1:0] RD_I = {1'b1, 4'b0001, 8'h11};
  localparam logic [TW-1:0] RD_D = {1'b1, 4'b0001, 8'h22};
  localparam logic [TW-1:0] WR_D = {1'b0, 4'b0001, 8'h33};

  bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BURST_BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .ibus_req(ibus_req), .ibus_reqcyc(ibus_reqcyc), .ibus_reqtag(ibus_reqtag),
    .ibus_reqack(ibus_reqack), .ibus_respcyc(ibus_respcyc), .ibus_resp(ibus_resp),
    .ibus_resptag(ibus_resptag), .ibus_respack(ibus_respack),
    .dbus_req(dbus_req), .dbus_reqcyc(dbus_reqcyc), .dbus_reqtag(dbus_reqtag),
    .dbus_reqack(dbus_reqack), .dbus_respcyc(dbus_respcyc), .dbus_resp(dbus_resp),
    .dbus_resptag(dbus_resptag), .dbus_respack(dbus_respack),
    .bus_req(bus_req), .bus_reqcyc(bus_reqcyc), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_pend = 0; m_beats = 0; m_last = 1;
  endtask

  // Compare every output against what the model's current owner implies.
  task automatic check_all();
    logic ei, ed;
    ei = (m_owner == 1);
    ed = (m_owner == 2);
    chk("m_bus_reqcyc", bus_reqcyc, ei ? ibus_reqcyc : ed ? dbus_reqcyc : 1'b0);
    chk("m_bus_req", bus_req, ei ? ibus_req : ed ? dbus_req : '0);
    chk("m_bus_reqtag", bus_reqtag, ei ? ibus_reqtag : ed ? dbus_reqtag : '0);
    chk("m_ibus_reqack", ibus_reqack, ei & bus_reqack);
    chk("m_dbus_reqack", dbus_reqack, ed & bus_reqack);
    chk("m_ibus_respcyc", ibus_respcyc, ei & bus_respcyc);
    chk("m_dbus_respcyc", dbus_respcyc, ed & bus_respcyc);
    chk("m_bus_respack", bus_respack, ei ? ibus_respack : ed ? dbus_respack : 1'b0);
    chk("m_ibus_resp", ibus_resp, bus_resp);
    chk("m_dbus_resptag", dbus_resptag, bus_resptag);
  endtask

  // Advance one clock; the model decides the next owner from the inputs as they stand now.
  task automatic tick();
    logic oc, ort, ora;
    int np, nb, no, nl;
    oc  = (m_owner == 1) ? ibus_reqcyc  : (m_owner == 2) ? dbus_reqcyc  : 1'b0;
    ort = (m_owner == 1) ? ibus_reqtag[TW-1] : dbus_reqtag[TW-1];
    ora = (m_owner == 1) ? ibus_respack : (m_owner == 2) ? dbus_respack : 1'b0;
    np = m_pend; nb = m_beats; no = m_owner; nl = m_last;
    if (m_owner != 0 && m_pend != 0 && bus_respcyc && ora) begin
      nb = m_beats + 1;
      if (nb == BEATS) begin nb = 0; np = 0; end
    end
    if (m_owner != 0 && oc && bus_reqack && ort) np = 1;
    if (m_owner == 0) begin
      if (dbus_reqcyc && ibus_reqcyc) begin
`ifdef ARB_ROUND_ROBIN_EN
        no = (m_last == 2) ? 1 : 2;
`else
        no = 2;
`endif
      end else if (dbus_reqcyc) no = 2;
      else if (ibus_reqcyc) no = 1;
      if (no != 0) nl = no;
    end else if (!oc && np == 0) begin
      no = 0;
    end
    @(posedge clk);
    #1;
    m_owner = no; m_pend = np; m_beats = nb; m_last = nl;
  endtask

  // Deliver a full burst to the given port (1 = ibus, 2 = dbus).
  task automatic burst(input int port, input logic [DW-1:0] base);
    for (int k = 0; k < BEATS; k++) begin
      bus_respcyc = 1'b1;
      bus_resp    = base + DW'(k);
      bus_resptag = RD_I;
      #1;
      chk("burst_own_respcyc", (port == 1) ? ibus_respcyc : dbus_respcyc, 1'b1);
      chk("burst_other_respcyc", (port == 1) ? dbus_respcyc : ibus_respcyc, 1'b0);
      chk("burst_resp", (port == 1) ? ibus_resp : dbus_resp, base + DW'(k));
      check_all();
      tick();
    end
    bus_respcyc = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    ibus_req = '0; dbus_req = '0; bus_resp = '0;
    ibus_reqtag = '0; dbus_reqtag = '0; bus_resptag = '0;
    ibus_reqcyc = 0; dbus_reqcyc = 0; ibus_respack = 0; dbus_respack = 0;
    bus_reqack = 0; bus_respcyc = 0;
    model_reset();
    #12;
    chk("rst_bus_reqcyc", bus_reqcyc, 1'b0);
    chk("rst_bus_respack", bus_respack, 1'b0);
    chk("rst_reqacks", {ibus_reqack, dbus_reqack}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single fetch read
    ibus_req = 64'h1000; ibus_reqtag = RD_I; ibus_reqcyc = 1;
    #1;
    chk("fetch_idle_cyc", bus_reqcyc, 1'b0);
    tick();
    chk("fetch_grant_cyc", bus_reqcyc, 1'b1);
    chk("fetch_grant_addr", bus_req, 64'h1000);
    bus_reqack = 1;
    #1;
    chk("fetch_ibus_reqack", ibus_reqack, 1'b1);
    chk("fetch_dbus_reqack", dbus_reqack, 1'b0);
    check_all();
    tick();
    ibus_reqcyc = 0; bus_reqack = 0; ibus_respack = 1;
    burst(1, 64'hA0);
    // Stray response once the grant has been released
    bus_respcyc = 1;
    #1;
    chk("stray_respack", bus_respack, 1'b0);
    chk("stray_ibus_respcyc", ibus_respcyc, 1'b0);
    chk("stray_dbus_respcyc", dbus_respcyc, 1'b0);
    check_all();
    bus_respcyc = 0; ibus_respack = 0;

    // Simultaneous reads: dbus first, ibus after release
    dbus_req = 64'h2000; dbus_reqtag = RD_D; dbus_reqcyc = 1;
    ibus_req = 64'h1040; ibus_reqtag = RD_I; ibus_reqcyc = 1;
    tick();
    chk("sim_first_addr", bus_req, 64'h2000);
    bus_reqack = 1;
    #1;
    chk("sim_dbus_reqack", dbus_reqack, 1'b1);
    chk("sim_ibus_held", ibus_reqack, 1'b0);
    tick();
    dbus_reqcyc = 0; bus_reqack = 0; dbus_respack = 1;
    burst(2, 64'hB0);
    dbus_respack = 0;
    #1;
    chk("sim_idle_gap", bus_reqcyc, 1'b0);
    check_all();
    tick();
    chk("sim_second_cyc", bus_reqcyc, 1'b1);
    chk("sim_second_addr", bus_req, 64'h1040);
    bus_reqack = 1;
    tick();
    ibus_reqcyc = 0; bus_reqack = 0; ibus_respack = 1;
    burst(1, 64'hC0);
    ibus_respack = 0;
    // Second simultaneous request, arbitration outcome from the model
    ibus_reqcyc = 1; dbus_reqcyc = 1;
    tick();
    check_all();
    ibus_reqcyc = 0; dbus_reqcyc = 0;
    tick();
    check_all();
    tick();

    // dbus write burst with ibus waiting
    dbus_req = 64'h3000; dbus_reqtag = WR_D; dbus_reqcyc = 1;
    tick();
    bus_reqack = 1;
    ibus_req = 64'h1080; ibus_reqtag = RD_I; ibus_reqcyc = 1;
    for (int k = 0; k < 9; k++) begin
      dbus_req = (k == 0) ? 64'h3000 : 64'hD0 + DW'(k);
      #1;
      chk("wr_dbus_reqack", dbus_reqack, 1'b1);
      chk("wr_ibus_reqack", ibus_reqack, 1'b0);
      chk("wr_bus_req", bus_req, dbus_req);
      check_all();
      tick();
    end
    dbus_reqcyc = 0;
    #1;
    chk("wr_still_owner", dbus_reqack, 1'b1);
    tick();
    chk("wr_released_cyc", bus_reqcyc, 1'b0);
    chk("wr_released_iack", ibus_reqack, 1'b0);
    tick();
    chk("wr_ibus_next_addr", bus_req, 64'h1080);
    bus_reqack = 0; ibus_reqcyc = 0;
    tick();
    check_all();

    // Reset during beat 4 of a read
    ibus_req = 64'h1100; ibus_reqtag = RD_I; ibus_reqcyc = 1;
    tick();
    bus_reqack = 1;
    tick();
    ibus_reqcyc = 0; bus_reqack = 0; ibus_respack = 1;
    for (int k = 0; k < 4; k++) begin
      bus_respcyc = 1; bus_resp = 64'hE0 + DW'(k);
      #1;
      check_all();
      tick();
    end
    bus_respcyc = 1; ibus_reqcyc = 1;
    #1;
    chk("rstmid_before_respack", bus_respack, 1'b1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("rstmid_bus_reqcyc", bus_reqcyc, 1'b0);
    chk("rstmid_bus_respack", bus_respack, 1'b0);
    chk("rstmid_ibus_respcyc", ibus_respcyc, 1'b0);
    bus_respcyc = 0; ibus_respack = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rstmid_idle_after", bus_reqcyc, 1'b0);
    tick();
    chk("rstmid_regrant_cyc", bus_reqcyc, 1'b1);
    chk("rstmid_regrant_addr", bus_req, 64'h1100);
    ibus_reqcyc = 0;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      ibus_reqcyc  = ($urandom_range(0, 2) == 0);
      dbus_reqcyc  = ($urandom_range(0, 2) == 0);
      ibus_reqtag  = TW'($urandom);
      dbus_reqtag  = TW'($urandom);
      ibus_req     = {$urandom, $urandom};
      dbus_req     = {$urandom, $urandom};
      bus_reqack   = 1'($urandom_range(0, 1));
      bus_respcyc  = 1'($urandom_range(0, 1));
      ibus_respack = ($urandom_range(0, 3) != 0);
      dbus_respack = ($urandom_range(0, 3) != 0);
      bus_resp     = {$urandom, $urandom};
      bus_resptag  = TW'($urandom);
      #1;
      check_all();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
